score_seg_encoder: RTL

Converts a 14-bit binary game score into four active-low seven-segment patterns for the 4-digit display scanner. It runs a sequential shift-and-add-3 (double-dabble) conversion, with optional leading-zero blanking. It sits between the game-logic score register and the display multiplexer: the multiplexer only scans and drives `digit`, and consumes the four patterns this block holds stable.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/bcd_seg_decode.sv | 29 ++
 rtl/score_seg_encoder.sv | 107 ++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment constants and encoder state type, also used by the
// display scanner and score/message overlays.
package seg_pkg;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Largest score the four-digit display can show
  localparam logic [13:0] SCORE_MAX = 14'd9999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD nibble to active-low seven-segment pattern, with blank.
module bcd_seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  // Digit lookup; blank request and non-decimal nibbles show nothing
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
    if (blank) seg = SEG_BLANK;
  end

endmodule

// File: rtl/score_seg_encoder.sv
// Sequential double-dabble score to four seven-segment patterns.
// Patterns only update in LATCH so the scanner never sees a partial value.
module score_seg_encoder
  import seg_pkg::*;
#(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] score,
  output logic        busy,
  output logic        done,
  output logic [6:0]  seg0,
  output logic [6:0]  seg1,
  output logic [6:0]  seg2,
  output logic [6:0]  seg3
);

  // Upper three digits at reset: blank when suppressing leading zeros
  localparam logic [6:0] SEG_RST_HI = BLANK_LZ ? SEG_BLANK : SEG_DIGIT[0];

  state_t      state, state_next;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic [15:0] bcd_adj;
  logic [3:0]  cnt;
  logic        blk1, blk2, blk3;
  logic [6:0]  dec0, dec1, dec2, dec3;

  // Add-3 correction on every nibble that would overflow past 9 when doubled
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Leading-zero blanking cascades from the thousands digit downwards
  always_comb begin
    blk3 = BLANK_LZ && (bcd[15:12] == 4'd0);
    blk2 = blk3 && (bcd[11:8] == 4'd0);
    blk1 = blk2 && (bcd[7:4] == 4'd0);
  end

  bcd_seg_decode u_dec0 (.nibble(bcd[3:0]),   .blank(1'b0), .seg(dec0));
  bcd_seg_decode u_dec1 (.nibble(bcd[7:4]),   .blank(blk1), .seg(dec1));
  bcd_seg_decode u_dec2 (.nibble(bcd[11:8]),  .blank(blk2), .seg(dec2));
  bcd_seg_decode u_dec3 (.nibble(bcd[15:12]), .blank(blk3), .seg(dec3));

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == 4'd0) state_next = LATCH;
      LATCH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath, status flags and output pattern registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin  <= '0;
      bcd  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      seg0 <= SEG_DIGIT[0];
      seg1 <= SEG_RST_HI;
      seg2 <= SEG_RST_HI;
      seg3 <= SEG_RST_HI;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == LATCH);
      case (state)
        IDLE: begin
          if (start) begin
            bin <= (score > SCORE_MAX) ? SCORE_MAX : score;
            bcd <= '0;
            cnt <= 4'd13;
          end
        end
        SHIFT: begin
          bcd <= {bcd_adj[14:0], bin[13]};
          bin <= {bin[12:0], 1'b0};
          cnt <= cnt - 4'd1;
        end
        LATCH: begin
          seg0 <= dec0;
          seg1 <= dec1;
          seg2 <= dec2;
          seg3 <= dec3;
        end
        default: ;
      endcase
    end
  end

endmodule
